tap_test_core: RTL and testbench
================================

// Module: tap_test_core
// PURPOSE
// - Debug tap: on every toggle of async global_ping, snapshot in_data with timing info.
// - Output word holds: cycles since previous ping event, upper in_data slice, and
//   in_data delta since previous snapshot.
// - Lets a logic analyser or readback path measure data rate between global pings.
// PARAMETERS
// - WIDTH_1      32  in_data width; must be >= WIDTH_2
// - WIDTH_2      16  width of each snapshot field
// - TIMER_WIDTH   8  interval counter width (saturating)
// PORTS
// - clk          in   1                       single system clock, rising edge
// - rst_n        in   1                       asynchronous, active-low reset
// - global_ping  in   1                       async ping; each edge (0->1 or 1->0) is one event
// - in_data      in   WIDTH_1                 data to tap, synchronous to clk
// - out_data     out  2*WIDTH_2+TIMER_WIDTH   {interval, snap_hi, delta_lo}, registered
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, rst_n).
// - Reset clears all flops to 0: sync chain, ping history, interval counter,
//   prev_lo, out_data. Reset mid-operation clears immediately; nothing pending survives.
// - global_ping goes through a 2-flop synchronizer (s1, s2), then a history flop s3.
// - event = s2 ^ s3.
// - Latency: out_data updates on the 3rd rising edge after global_ping changes,
//   counting the edge that first samples the new level as 1st.
// - Event on the same edge as reset release: history is 0, so a ping already high at
//   reset release produces one event 3 edges later. This is required behaviour.
// - Interval counter cnt (TIMER_WIDTH):
//   - on event: cnt <= 0;
//   - otherwise: cnt <= cnt+1, saturating at all-ones.
// - On event edge, out_data <= {ivl, snap_hi, delta_lo}:
//   - ivl      = sat(cnt+1) = clk cycles since previous event (all-ones if >= 2^TW-1);
//   - snap_hi  = in_data[WIDTH_1-1 -: WIDTH_2], sampled at that edge;
//   - delta_lo = in_data[WIDTH_2-1:0] - prev_lo, modulo 2^WIDTH_2 (wraps, no flag).
//   - Same edge: prev_lo <= in_data[WIDTH_2-1:0].
// - First event after reset: prev_lo=0, so delta_lo = raw low slice.
//   ivl counts from reset release.
// - out_data holds its value between events; no valid strobe.
// - Back-to-back events (ping toggling faster than the synchronizer) are
//   sampled-level based. Pulses shorter than one clk may be lost. Not an error.
// - Pure synchronous datapath after the synchronizer; no combinational path from
//   inputs to out_data.
// TESTING
// - Reset: rst_n=0 with ping toggling -> out_data=0x00_0000_0000;
//   no updates until rst_n=1.
// - Periodic ping: clk 10ns; in_data +1 per cycle; ping toggles every 100ns ->
//   from 2nd event on, ivl=0x0A and delta_lo=0x000A.
//   snap_hi = in_data[31:16] at the event edge.
// - Latency: single ping rise at a known edge -> out_data changes exactly 3 edges later.
//   Unchanged on edges 1-2.
// - Saturation: ping idle 300 cycles, then toggle -> ivl=0xFF.
//   Next toggle 5 cycles later -> ivl=0x05.
// - Wrap: prev_lo=0xFFF0, then in_data[15:0]=0x0010 at event -> delta_lo=0x0020.
// - Async reset mid-run: drop rst_n between edges -> out_data=0 immediately, not at next edge.
//   First event after release reports delta_lo = raw in_data[15:0].

Source files
------------

// File: rtl/tap_test_core.sv
// -----------------------------------------------------------------------------
// tap_test_core
// Debug tap. Every edge (rise or fall) of the asynchronous global_ping input is
// one event. On each event the tap captures a word of timing and data
// information so that a logic analyser or readback path can measure the data
// rate between pings.
//
// out_data = {interval, snap_hi, delta_lo}
//   interval : clock cycles since the previous event. The count starts from
//              reset release for the first event, and saturates at all-ones.
//   snap_hi  : upper WIDTH_2 bits of in_data at the event edge.
//   delta_lo : low WIDTH_2 bits of in_data minus the low slice captured at the
//              previous event, modulo 2^WIDTH_2. This is raw for the first
//              event after reset.
//
// Parameters
//   WIDTH_1     : in_data width, must be >= WIDTH_2
//   WIDTH_2     : width of the snap_hi and delta_lo fields
//   TIMER_WIDTH : width of the saturating interval counter
//
// Ports
//   clk         in   rising-edge system clock
//   rst_n       in   asynchronous active-low reset, clears every flop
//   global_ping in   asynchronous ping, each level change is one event
//   in_data     in   WIDTH_1 data word, synchronous to clk
//   out_data    out  2*WIDTH_2+TIMER_WIDTH captured word, registered, held
//                    between events
// -----------------------------------------------------------------------------
module tap_test_core #(
    parameter int WIDTH_1     = 32,
    parameter int WIDTH_2     = 16,
    parameter int TIMER_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               global_ping,
    input  logic [WIDTH_1-1:0]                 in_data,
    output logic [2*WIDTH_2+TIMER_WIDTH-1:0]   out_data
);

    localparam int OUT_W = 2 * WIDTH_2 + TIMER_WIDTH;

    // Synchronizer stages (s1_q, s2_q) and the history flop (s3_q).
    logic                   s1_q;
    logic                   s2_q;
    logic                   s3_q;
    logic                   event_s;

    logic [TIMER_WIDTH-1:0] cnt_q;
    logic [TIMER_WIDTH-1:0] cnt_d;
    logic [TIMER_WIDTH-1:0] cnt_inc_s;
    logic [WIDTH_2-1:0]     prev_lo_q;
    logic [WIDTH_2-1:0]     prev_lo_d;
    logic [OUT_W-1:0]       out_q;
    logic [OUT_W-1:0]       out_d;

    // The synchronized level differs from the level seen one cycle earlier.
    assign event_s = s2_q ^ s3_q;

    // The incremented count saturates at all-ones. This value is the next idle
    // count, and it is also the reported interval. The interval includes the
    // event edge itself.
    assign cnt_inc_s = (cnt_q == {TIMER_WIDTH{1'b1}}) ? cnt_q
                                                      : cnt_q + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    // Next-state logic: capture on an event, otherwise count and hold.
    always_comb begin
        cnt_d     = cnt_q;
        prev_lo_d = prev_lo_q;
        out_d     = out_q;
        if (event_s) begin
            cnt_d     = {TIMER_WIDTH{1'b0}};
            prev_lo_d = in_data[WIDTH_2-1:0];
            out_d     = {cnt_inc_s,
                         in_data[WIDTH_1-1 -: WIDTH_2],
                         in_data[WIDTH_2-1:0] - prev_lo_q};
        end else begin
            cnt_d     = cnt_inc_s;
            prev_lo_d = prev_lo_q;
            out_d     = out_q;
        end
    end

    // Ping synchronizer and history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= global_ping;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Interval counter, previous low slice and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {TIMER_WIDTH{1'b0}};
            prev_lo_q <= {WIDTH_2{1'b0}};
            out_q     <= {OUT_W{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            prev_lo_q <= prev_lo_d;
            out_q     <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_tap_test_core.sv
module tb_tap_test_core;

    logic        clk;
    logic        rst_n;
    logic        global_ping;
    logic [31:0] in_data;
    logic [39:0] out_data;

    int checks;
    int failures;

    tap_test_core #(.WIDTH_1(32), .WIDTH_2(16), .TIMER_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .global_ping (global_ping),
        .in_data     (in_data),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It records the ping level seen at every edge since
    // reset release. An event fires at edge n when the level seen at edge n-2
    // differs from the level seen at edge n-3. Levels before release count as 0.
    bit          samp_q[$];
    int          edge_n;
    int          last_ev;
    logic [15:0] m_prev_lo;
    logic [39:0] exp_out;

    function automatic bit lvl(int idx);
        if (idx < 1) return 1'b0;
        return samp_q[idx-1];
    endfunction

    task automatic model_reset();
        samp_q.delete();
        edge_n    = 0;
        last_ev   = 0;
        m_prev_lo = 16'h0000;
        exp_out   = 40'h0;
    endtask

    task automatic model_edge();
        int ivl;
        edge_n++;
        samp_q.push_back(global_ping);
        if (lvl(edge_n - 2) != lvl(edge_n - 3)) begin
            ivl = edge_n - last_ev;
            if (ivl > 255) ivl = 255;
            exp_out   = {ivl[7:0], in_data[31:16], in_data[15:0] - m_prev_lo};
            m_prev_lo = in_data[15:0];
            last_ev   = edge_n;
        end
    endtask

    task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One clock: the model follows the edge, then the DUT is compared on the
    // falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        chk("cycle", out_data, exp_out);
    endtask

    // Called at a falling edge. Reset is asserted between edges and must take
    // effect at once.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_rst", out_data, 40'h0);
        model_reset();
        step();
        step();
    endtask

    typedef struct {
        int          gap;
        logic [31:0] data;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [39:0] old;
        checks   = 0;
        failures = 0;
        rst_n       = 1'b0;
        global_ping = 1'b0;
        in_data     = 32'h0;
        model_reset();
        @(negedge clk);
        chk("rst_state", out_data, 40'h0);

        // The ping toggles while reset is held. No update may occur.
        for (int i = 0; i < 6; i++) begin
            global_ping = ~global_ping;
            in_data     = $urandom;
            step();
            chk("rst_hold", out_data, 40'h0);
        end

        // The ping is already high at release, so one event occurs 3 edges later.
        global_ping = 1'b1;
        in_data     = 32'hCAFE_0123;
        rst_n       = 1'b1;
        step(); step();
        chk("rel_e2", out_data, 40'h0);
        step();
        chk("rel_e3", out_data, 40'h03_CAFE_0123);

        // Table. Each record toggles the ping, then holds the data for gap cycles.
        vecs[0] = '{5,   32'h1234_FFF0, 40'h03_1234_FFF0};
        vecs[1] = '{10,  32'hABCD_0010, 40'h05_ABCD_0020};
        vecs[2] = '{4,   32'h0000_0010, 40'h0A_0000_0000};
        vecs[3] = '{300, 32'hFFFF_0015, 40'h04_FFFF_0005};
        vecs[4] = '{5,   32'h5555_0000, 40'hFF_5555_FFEB};
        vecs[5] = '{254, 32'h8000_7FFF, 40'h05_8000_7FFF};
        vecs[6] = '{255, 32'h0001_0000, 40'hFE_0001_8001};
        vecs[7] = '{3,   32'h0002_0001, 40'hFF_0002_0001};
        apply_reset();
        global_ping = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            global_ping = ~global_ping;
            in_data     = vecs[i].data;
            for (int c = 0; c < vecs[i].gap; c++) step();
            chk($sformatf("vec%0d", i), out_data, vecs[i].exp);
        end

        // Periodic ping every 10 cycles while in_data counts up by one each cycle.
        apply_reset();
        global_ping = 1'b0;
        in_data     = 32'h0042_FFF8;
        rst_n       = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            global_ping = ~global_ping;
            for (int c = 0; c < 10; c++) begin
                step();
                in_data = in_data + 32'd1;
            end
            if (k >= 2) begin
                chk("per_ivl",   {32'h0, out_data[39:32]}, {32'h0, 8'h0A});
                chk("per_delta", {24'h0, out_data[15:0]},  {24'h0, 16'h000A});
            end
        end

        // Latency: the output is unchanged on edges 1 and 2 and changes on edge 3.
        for (int c = 0; c < 20; c++) step();
        old         = out_data;
        global_ping = ~global_ping;
        in_data     = 32'h7777_1111;
        step(); chk("lat_e1", out_data, old);
        step(); chk("lat_e2", out_data, old);
        step(); chk("lat_e3", out_data, exp_out);
        checks++;
        if (out_data === old) begin
            failures++;
            $display("FAIL lat_changed actual=%h required=not %h", out_data, old);
        end

        // Mid-run async reset. The ping is high at release, and the first event
        // reports the raw low slice.
        global_ping = 1'b1;
        step();
        apply_reset();
        in_data = 32'h1357_9BDF;
        rst_n   = 1'b1;
        step(); step(); step();
        chk("post_rst", out_data, 40'h03_1357_9BDF);

        // Randomised run against the model, with idle bursts and one reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                apply_reset();
                rst_n = 1'b1;
            end
            if ((c % 700) < 280) begin
                if ($urandom_range(0, 99) == 0) global_ping = ~global_ping;
            end else begin
                if ($urandom_range(0, 3) == 0) global_ping = ~global_ping;
            end
            in_data = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
